seq_pipe_add_nstage: RTL and testbench



---
 rtl/seq_pipe_add_nstage_pkg.sv | 17 +
 rtl/seq_pipe_add_stage.sv | 74 +++++++
 rtl/seq_pipe_add_nstage.sv | 78 +++++++
 tb/tb_seq_pipe_add_nstage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pipe_add_nstage_pkg.sv
// Shared defaults and elaboration-time helpers for the chunked pipelined adder.
package seq_pipe_add_nstage_pkg;

    localparam int DEF_NBITS   = 32;
    localparam int DEF_NSTAGES = 4;

    // Width of the slice each stage adds.
    function automatic int chunk_bits(input int nbits, input int nstages);
        return nbits / nstages;
    endfunction

    // Number of operand bits still left to add after stage k has finished.
    function automatic int rem_bits(input int nbits, input int cbits, input int k);
        return nbits - ((k + 1) * cbits);
    endfunction

endpackage

// File: rtl/seq_pipe_add_stage.sv
// One pipeline stage: adds the lowest chunk of the remaining operands plus
// the incoming carry, and registers the partial sum with its handshake state.
// Operands arrive pre-shifted so the chunk to add always sits at bit 0; the
// stage shifts them down again for its successor. Sum bits not yet produced
// are zero, so each stage ORs its chunk in at position POS.
module seq_pipe_add_stage
    import seq_pipe_add_nstage_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int CBITS   = 8,
    parameter int REMBITS = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_val,
    input  logic             i_carry,
    input  logic [NBITS-1:0] i_sum,
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    input  logic             i_rdy_next,
    output logic             o_rdy,
    output logic             o_val,
    output logic             o_carry,
    output logic [NBITS-1:0] o_sum,
    output logic [NBITS-1:0] o_a,
    output logic [NBITS-1:0] o_b
);

    localparam int POS = NBITS - REMBITS - CBITS;

    logic             r_val;
    logic             r_carry;
    logic [NBITS-1:0] r_sum;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [CBITS:0]   w_chunk;

    assign w_chunk = {1'b0, i_a[CBITS-1:0]} + {1'b0, i_b[CBITS-1:0]}
                   + {{CBITS{1'b0}}, i_carry};

    // This register can take new data when it is empty or when the slot
    // downstream will drain it this same cycle.
    assign o_rdy = !r_val || i_rdy_next;

    // Stage register: clear on reset, load from upstream when ready, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= {NBITS{1'b0}};
            r_a     <= {NBITS{1'b0}};
            r_b     <= {NBITS{1'b0}};
        end else if (o_rdy) begin
            r_val   <= i_val;
            r_carry <= w_chunk[CBITS];
            r_sum   <= i_sum | (NBITS'(w_chunk[CBITS-1:0]) << POS);
            r_a     <= i_a >> CBITS;
            r_b     <= i_b >> CBITS;
        end else begin
            r_val   <= r_val;
            r_carry <= r_carry;
            r_sum   <= r_sum;
            r_a     <= r_a;
            r_b     <= r_b;
        end
    end

    assign o_val   = r_val;
    assign o_carry = r_carry;
    assign o_sum   = r_sum;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

// File: rtl/seq_pipe_add_nstage.sv
// NBITS-wide adder split into NSTAGES chunk stages with valid/ready flow
// control. The ready chain runs combinationally from out_rdy back to in_rdy,
// so entries compact into bubbles under back-pressure and a full pipe still
// streams one result per cycle while the consumer is ready.
module seq_pipe_add_nstage
    import seq_pipe_add_nstage_pkg::*;
#(
    parameter int NBITS   = DEF_NBITS,
    parameter int NSTAGES = DEF_NSTAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic             cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out,
    output logic             cout
);

    localparam int CBITS = chunk_bits(NBITS, NSTAGES);

    generate
        if ((NSTAGES < 1) || (NSTAGES > NBITS) || ((NBITS % NSTAGES) != 0)) begin : g_bad_params
            $error("seq_pipe_add_nstage: NBITS must be a multiple of NSTAGES, 1 <= NSTAGES <= NBITS");
        end
    endgenerate

    // Index k is the boundary in front of stage k; index NSTAGES is the output.
    logic             w_val   [0:NSTAGES];
    logic             w_carry [0:NSTAGES];
    logic             w_rdy   [0:NSTAGES];
    logic [NBITS-1:0] w_sum   [0:NSTAGES];
    logic [NBITS-1:0] w_a     [0:NSTAGES];
    logic [NBITS-1:0] w_b     [0:NSTAGES];

    assign w_val[0]       = in_val;
    assign w_carry[0]     = cin;
    assign w_sum[0]       = {NBITS{1'b0}};
    assign w_a[0]         = in0;
    assign w_b[0]         = in1;
    assign w_rdy[NSTAGES] = out_rdy;

    generate
        for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
            seq_pipe_add_stage #(
                .NBITS   (NBITS),
                .CBITS   (CBITS),
                .REMBITS (rem_bits(NBITS, CBITS, k))
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .i_val      (w_val[k]),
                .i_carry    (w_carry[k]),
                .i_sum      (w_sum[k]),
                .i_a        (w_a[k]),
                .i_b        (w_b[k]),
                .i_rdy_next (w_rdy[k+1]),
                .o_rdy      (w_rdy[k]),
                .o_val      (w_val[k+1]),
                .o_carry    (w_carry[k+1]),
                .o_sum      (w_sum[k+1]),
                .o_a        (w_a[k+1]),
                .o_b        (w_b[k+1])
            );
        end
    endgenerate

    // Stage 0 only loads when ready, so loading in_val equals in_val && in_rdy.
    assign in_rdy  = w_rdy[0];
    assign out_val = w_val[NSTAGES];
    assign out     = w_sum[NSTAGES];
    assign cout    = w_carry[NSTAGES];

endmodule

// File: tb/tb_seq_pipe_add_nstage.sv
// Directed + random bench for seq_pipe_add_nstage with a result scoreboard.
module tb_seq_pipe_add_nstage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main 32-bit / 4-stage instance.
    logic        a_in_val = 1'b0, a_in_rdy, a_cin = 1'b0, a_out_val, a_out_rdy = 1'b0, a_cout;
    logic [31:0] a_in0 = 32'd0, a_in1 = 32'd0, a_out;

    // Degenerate 8-bit instances: one stage and eight stages.
    logic       b_in_val = 1'b0, b_cin = 1'b0, b_out_rdy = 1'b1;
    logic [7:0] b_in0 = 8'd0, b_in1 = 8'd0;
    logic       b1_in_rdy, b1_out_val, b1_cout, b8_in_rdy, b8_out_val, b8_cout;
    logic [7:0] b1_out, b8_out;

    seq_pipe_add_nstage #(.NBITS(32), .NSTAGES(4)) u_dut (
        .clk(clk), .reset(reset), .in_val(a_in_val), .in_rdy(a_in_rdy),
        .in0(a_in0), .in1(a_in1), .cin(a_cin), .out_val(a_out_val),
        .out_rdy(a_out_rdy), .out(a_out), .cout(a_cout));

    seq_pipe_add_nstage #(.NBITS(8), .NSTAGES(1)) u_dut_s1 (
        .clk(clk), .reset(reset), .in_val(b_in_val), .in_rdy(b1_in_rdy),
        .in0(b_in0), .in1(b_in1), .cin(b_cin), .out_val(b1_out_val),
        .out_rdy(b_out_rdy), .out(b1_out), .cout(b1_cout));

    seq_pipe_add_nstage #(.NBITS(8), .NSTAGES(8)) u_dut_s8 (
        .clk(clk), .reset(reset), .in_val(b_in_val), .in_rdy(b8_in_rdy),
        .in0(b_in0), .in1(b_in1), .cin(b_cin), .out_val(b8_out_val),
        .out_rdy(b_out_rdy), .out(b8_out), .cout(b8_cout));

    int          total = 0;
    int          bad   = 0;
    int          n_in  = 0;
    int          n_out = 0;
    logic [32:0] sb [$];
    logic        hold_prev = 1'b0;
    logic [32:0] hold_data = 33'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the main DUT: drive at negedge, then account for the
    // transfers that the following posedge will perform.
    task automatic step_a(input logic rst, input logic v, input logic [31:0] x,
                          input logic [31:0] y, input logic c, input logic ordy,
                          output logic acc);
        logic [32:0] e;
        @(negedge clk);
        reset = rst; a_in_val = v; a_in0 = x; a_in1 = y; a_cin = c; a_out_rdy = ordy;
        #1;
        acc = v && a_in_rdy && !rst;
        if (rst) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_val", a_out_val, 1);
                chk("hold_data", {a_cout, a_out}, hold_data);
            end
            if (acc) begin
                sb.push_back({1'b0, x} + {1'b0, y} + {32'd0, c});
                n_in++;
            end
            if (a_out_val && a_out_rdy) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_data", {a_cout, a_out}, e);
                end
                n_out++;
            end
            hold_prev = a_out_val && !a_out_rdy;
            hold_data = {a_cout, a_out};
        end
    endtask

    // Single transaction with out_rdy high: out_val exactly 4 cycles later.
    task automatic run_single(input logic [31:0] x, input logic [31:0] y,
                              input logic c, input logic [32:0] want);
        logic acc;
        step_a(1'b0, 1'b1, x, y, c, 1'b1, acc);
        chk("single_acc", acc, 1);
        for (int i = 1; i <= 6; i++) begin
            step_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
            chk($sformatf("lat_cyc%0d", i), a_out_val, (i == 4));
            if (i == 4) chk("direct_sum", {a_cout, a_out}, want);
        end
    endtask

    task automatic step_b(input logic v, input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        b_in_val = v; b_in0 = x; b_in1 = y; b_cin = c;
        #1;
    endtask

    initial begin
        logic acc;
        int   idx, acc_cnt, base, lat1, lat8;
        logic [7:0] x8, y8;
        logic c8;
        logic [8:0] e9;

        // Reset and post-reset state.
        step_a(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        step_a(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        step_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        chk("rst_out_val", a_out_val, 0);
        chk("rst_out", a_out, 0);
        chk("rst_cout", a_cout, 0);
        chk("rst_in_rdy", a_in_rdy, 1);

        // Basic and carry-crossing sums.
        run_single(32'h0000_0003, 32'h0000_0004, 1'b0, 33'h0_0000_0007);
        run_single(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        run_single(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100);

        // Back-pressure: only four entries fit, head result holds at 2.
        idx = 1; acc_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            step_a(1'b0, 1'b1, idx, idx, 1'b0, 1'b0, acc);
            if (acc) begin idx++; acc_cnt++; end
            if (s >= 4) begin
                chk("bp_in_rdy_low", a_in_rdy, 0);
                chk("bp_out_val", a_out_val, 1);
                chk("bp_head", {a_cout, a_out}, 33'd2);
            end
        end
        chk("bp_accepts", acc_cnt, 4);
        base = n_out;
        for (int s = 0; s < 40 && !(idx > 6 && (n_out - base) == 6); s++) begin
            step_a(1'b0, (idx <= 6), idx, idx, 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_drained", n_out - base, 6);
        chk("bp_sb_empty", sb.size(), 0);

        // Alternating valid with random back-pressure, then drain.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            y = $urandom;
            step_a(1'b0, cyc[0], x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
        end
        for (int s = 0; s < 30; s++) step_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        chk("conserve", n_in, n_out);
        chk("rand_sb_empty", sb.size(), 0);

        // Reset mid-flight, with an input offered during reset.
        for (int s = 0; s < 3; s++) step_a(1'b0, 1'b1, 32'd100 + s, 32'd7, 1'b1, 1'b1, acc);
        step_a(1'b1, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0, acc);
        step_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        chk("mid_rst_out_val", a_out_val, 0);
        chk("mid_rst_out", a_out, 0);
        chk("mid_rst_cout", a_cout, 0);
        chk("mid_rst_in_rdy", a_in_rdy, 1);
        for (int s = 0; s < 12; s++) begin
            step_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
            chk("post_rst_idle", a_out_val, 0);
        end

        // Degenerate configurations: latency 1 and 8.
        for (int t = 0; t < 6; t++) begin
            x8 = (t == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            y8 = (t == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            c8 = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            e9 = {1'b0, x8} + {1'b0, y8} + {8'd0, c8};
            step_b(1'b1, x8, y8, c8);
            chk("s1_in_rdy", b1_in_rdy, 1);
            chk("s8_in_rdy", b8_in_rdy, 1);
            lat1 = 0; lat8 = 0;
            for (int i = 1; i <= 12; i++) begin
                step_b(1'b0, 8'd0, 8'd0, 1'b0);
                if (b1_out_val) begin
                    if (lat1 == 0) lat1 = i;
                    chk("s1_sum", {b1_cout, b1_out}, e9);
                end
                if (b8_out_val) begin
                    if (lat8 == 0) lat8 = i;
                    chk("s8_sum", {b8_cout, b8_out}, e9);
                end
            end
            chk("s1_latency", lat1, 1);
            chk("s8_latency", lat8, 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
